// File: rtl/irq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// irq_pkg: shared FSM encoding, register offsets, exception codes and vectors
// Rev 1.0
// ----------------------------------------------------------------------------
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } irq_state_e;

  localparam logic [3:0] OFF_IMASK  = 4'd0;
  localparam logic [3:0] OFF_IPEND  = 4'd4;
  localparam logic [3:0] OFF_ICAUSE = 4'd8;
  localparam logic [3:0] OFF_ICTRL  = 4'd12;

  localparam logic [2:0] EXC_ALU_OVF = 3'd0;
  localparam logic [2:0] EXC_PC_OVF  = 3'd1;
  localparam logic [2:0] EXC_HAZARD  = 3'd2;

  // Handler entry points consumed by the PC logic, not by this block
  localparam logic [31:0] IRQ_VECTOR = 32'h80000004;
  localparam logic [31:0] EXC_VECTOR = 32'h80000008;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// ----------------------------------------------------------------------------
// irq_prio_enc: lowest-index-first priority encoder with valid flag (W <= 8)
// Rev 1.0
// ----------------------------------------------------------------------------
module irq_prio_enc #(
  parameter int W = 4
) (
  input  logic [W-1:0] req,
  output logic         valid,
  output logic [2:0]   idx
);

  // Scanning downward lets the lowest set index win the last assignment
  always_comb begin
    valid = |req;
    idx   = 3'd0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) idx = 3'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/irq_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// irq_controller: edge-latched interrupts, exception forwarding, MMIO regs
// Rev 1.0
// ----------------------------------------------------------------------------
module irq_controller
  import irq_pkg::*;
#(
  parameter int          NSRC      = 4,
  parameter logic [31:0] BASE_ADDR = 32'h40000030
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irq_src,
  input  logic [2:0]      exc_src,
  input  logic            kernel,
  input  logic            MemRd,
  input  logic            MemWr,
  input  logic [31:0]     Addr,
  input  logic [31:0]     WriteData,
  output logic [31:0]     ReadData,
  output logic            Interrupt,
  output logic            Exception,
  output logic            in_service
);

  irq_state_e state, state_next;

  logic [NSRC-1:0] src_q, imask, ipend;
  logic [NSRC-1:0] new_event, ipend_w1c, pend_en;
  logic            gie;
  logic [2:0]      sticky;
  logic            cause_exc;
  logic [2:0]      cause_id;

  logic [29:0] word_off;
  logic        blk_hit;
  logic [3:0]  reg_off;
  logic        wr_imask, wr_ipend, wr_ictrl;

  logic       irq_valid, exc_valid;
  logic [2:0] irq_idx, exc_idx;
  logic       load_irq, load_exc;

  // Word-granular decode so a non-16-aligned BASE_ADDR still maps correctly
  assign word_off = Addr[31:2] - BASE_ADDR[31:2];
  assign blk_hit  = (word_off[29:2] == 28'd0);
  assign reg_off  = {word_off[1:0], 2'b00};

  assign wr_imask = MemWr && blk_hit && (reg_off == OFF_IMASK);
  assign wr_ipend = MemWr && blk_hit && (reg_off == OFF_IPEND);
  assign wr_ictrl = MemWr && blk_hit && (reg_off == OFF_ICTRL);

  assign new_event = irq_src & ~src_q;
  assign ipend_w1c = wr_ipend ? WriteData[NSRC-1:0] : '0;
  assign pend_en   = ipend & imask;

  irq_prio_enc #(.W(NSRC)) u_irq_enc (
    .req   (pend_en),
    .valid (irq_valid),
    .idx   (irq_idx)
  );

  irq_prio_enc #(.W(3)) u_exc_enc (
    .req   (exc_src),
    .valid (exc_valid),
    .idx   (exc_idx)
  );

  // The faulting instruction must trap in the cycle it executes
  assign Exception = exc_valid && !kernel;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      src_q     <= '0;
      imask     <= '0;
      ipend     <= '0;
      gie       <= 1'b0;
      sticky    <= 3'b000;
      cause_exc <= 1'b0;
      cause_id  <= 3'd0;
    end else begin
      state  <= state_next;
      src_q  <= irq_src;
      ipend  <= (ipend & ~ipend_w1c) | new_event;
      sticky <= (sticky & ~(wr_ictrl ? WriteData[10:8] : 3'b000)) | exc_src;
      if (wr_imask) imask <= WriteData[NSRC-1:0];
      if (wr_ictrl) gie <= WriteData[0];
      if (load_exc) begin
        cause_exc <= 1'b1;
        cause_id  <= exc_idx;
      end else if (load_irq) begin
        cause_exc <= 1'b0;
        cause_id  <= irq_idx;
      end
    end
  end

  always_comb begin
    state_next = state;
    Interrupt  = 1'b0;
    in_service = 1'b0;
    load_irq   = 1'b0;
    load_exc   = 1'b0;
    case (state)
      IDLE: begin
        if (Exception) begin
          load_exc   = 1'b1;
          state_next = SVC;
        end else if (gie && irq_valid && !kernel) begin
          load_irq   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        Interrupt = !kernel;
        if (Exception) begin
          load_exc   = 1'b1;
          state_next = SVC;
        end else if (kernel) begin
          state_next = SVC;
        end
      end
      SVC: begin
        in_service = 1'b1;
        if (!kernel) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    ReadData = 32'h0;
    if (MemRd && blk_hit) begin
      case (reg_off)
        OFF_IMASK:  ReadData[NSRC-1:0] = imask;
        OFF_IPEND:  ReadData[NSRC-1:0] = ipend;
        OFF_ICAUSE: begin
          ReadData[31]  = cause_exc;
          ReadData[2:0] = cause_id;
        end
        OFF_ICTRL: begin
          ReadData[10:8] = sticky;
          ReadData[0]    = gie;
        end
        default: ReadData = 32'h0;
      endcase
    end
  end

  logic unused_bits;
  assign unused_bits = ^{Addr[1:0], WriteData};

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_irq_controller: directed and random checks against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_irq_controller;

  localparam logic [31:0] BASE = 32'h40000030;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  irq_src = 4'h0;
  logic [2:0]  exc_src = 3'b000;
  logic        kernel = 1'b0;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        Interrupt, Exception, in_service;

  int errors = 0;
  int checks = 0;

  // Model: phase 0 = user mode, 1 = request raised, 2 = handler running
  logic [3:0] m_imask, m_ipend, m_src;
  logic       m_gie, m_cexc;
  logic [2:0] m_sticky, m_cid;
  int         m_phase;

  always #10 clk = ~clk;

  irq_controller #(.NSRC(4), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .irq_src    (irq_src),
    .exc_src    (exc_src),
    .kernel     (kernel),
    .MemRd      (MemRd),
    .MemWr      (MemWr),
    .Addr       (Addr),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .Interrupt  (Interrupt),
    .Exception  (Exception),
    .in_service (in_service)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] first_set(input logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return 3'(i);
    return 3'd0;
  endfunction

  function automatic logic [31:0] model_read(input int r);
    case (r)
      0: return {28'h0, m_imask};
      1: return {28'h0, m_ipend};
      2: return {m_cexc, 28'h0, m_cid};
      3: return {21'h0, m_sticky, 7'h0, m_gie};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_imask = 0; m_ipend = 0; m_src = 0; m_gie = 0; m_cexc = 0;
    m_sticky = 0; m_cid = 0; m_phase = 0;
  endtask

  // Advance one clock edge, evolving the model from the pre-edge inputs
  task automatic tick();
    logic [31:0] off;
    logic        hit, exc_now;
    int          r, n_phase;
    logic [3:0]  ne, w1c, n_ipend, n_imask, s;
    logic        n_gie, n_cexc;
    logic [2:0]  n_sticky, n_cid;
    off = Addr - BASE;
    hit = MemWr && (off < 32'd16);
    r   = int'(off[3:2]);
    s   = irq_src;
    ne  = irq_src & ~m_src;
    w1c = (hit && r == 1) ? WriteData[3:0] : 4'h0;
    n_ipend  = (m_ipend & ~w1c) | ne;
    n_imask  = (hit && r == 0) ? WriteData[3:0] : m_imask;
    n_gie    = (hit && r == 3) ? WriteData[0] : m_gie;
    n_sticky = (m_sticky & ~((hit && r == 3) ? WriteData[10:8] : 3'b000)) | exc_src;
    n_cexc = m_cexc; n_cid = m_cid; n_phase = m_phase;
    exc_now = (exc_src != 3'b000) && !kernel;
    if (m_phase == 0) begin
      if (exc_now) begin
        n_cexc = 1; n_cid = first_set({5'b0, exc_src}); n_phase = 2;
      end else if (m_gie && (m_ipend & m_imask) != 0 && !kernel) begin
        n_cexc = 0; n_cid = first_set({4'b0, m_ipend & m_imask}); n_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (exc_now) begin
        n_cexc = 1; n_cid = first_set({5'b0, exc_src}); n_phase = 2;
      end else if (kernel) n_phase = 2;
    end else if (!kernel) n_phase = 0;
    @(posedge clk);
    #1;
    if (!reset) model_reset();
    else begin
      m_ipend = n_ipend; m_imask = n_imask; m_gie = n_gie; m_sticky = n_sticky;
      m_cexc = n_cexc; m_cid = n_cid; m_phase = n_phase; m_src = s;
    end
  endtask

  task automatic rd(input int r, output logic [31:0] v);
    MemRd = 1; Addr = BASE + 32'(r * 4) + 32'($urandom_range(0, 3)); #1;
    v = ReadData;
    MemRd = 0; Addr = 32'h0;
  endtask

  task automatic wr(input int r, input logic [31:0] d);
    MemWr = 1; Addr = BASE + 32'(r * 4); WriteData = d;
    tick();
    MemWr = 0; Addr = 32'h0; WriteData = 32'h0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] v;
    chk({tag, "/Interrupt"}, 32'(Interrupt), 32'(m_phase == 1 && !kernel));
    chk({tag, "/Exception"}, 32'(Exception), 32'(exc_src != 3'b000 && !kernel));
    chk({tag, "/in_service"}, 32'(in_service), 32'(m_phase == 2));
    for (int r = 0; r < 5; r++) begin
      rd(r, v);
      chk($sformatf("%s/reg%0d", tag, r), v, model_read(r));
    end
    Addr = BASE; #1;
    chk({tag, "/rd_idle"}, ReadData, 32'h0);
    Addr = 32'h0;
  endtask

  initial begin
    logic [31:0] v;
    model_reset();
    #25;
    check_all("reset");
    reset = 1;
    tick();

    // Single source, full latency walk
    wr(0, 32'h1); wr(3, 32'h1);
    irq_src = 4'h1; tick();
    irq_src = 4'h0;
    rd(1, v); chk("t1_ipend_E1", v, 32'h1);
    chk("t1_int_E1", 32'(Interrupt), 32'h0);
    tick();
    chk("t1_int_E2", 32'(Interrupt), 32'h1);
    check_all("t1_E2");
    tick(); kernel = 1; #1;
    chk("t1_int_E3", 32'(Interrupt), 32'h0);
    tick();
    chk("t1_svc_E4", 32'(in_service), 32'h1);
    rd(2, v); chk("t1_icause", v, 32'h0);
    wr(1, 32'h1); kernel = 0; tick();
    check_all("t1_ret");

    // Simultaneous edges: lowest index first, re-request after return
    wr(0, 32'hF);
    irq_src = 4'h6; tick(); irq_src = 4'h0; tick();
    chk("t2_int", 32'(Interrupt), 32'h1);
    rd(2, v); chk("t2_cause1", v, 32'h1);
    kernel = 1; tick(); wr(1, 32'h2); kernel = 0; tick();
    chk("t2_idle_gap", 32'(Interrupt), 32'h0);
    tick();
    chk("t2_reint", 32'(Interrupt), 32'h1);
    rd(2, v); chk("t2_cause2", v, 32'h2);
    check_all("t2");
    kernel = 1; tick(); wr(1, 32'h4); kernel = 0; tick();
    check_all("t2_ret");

    // Masked pending bit fires once enabled
    wr(0, 32'h0);
    irq_src = 4'h8; tick(); irq_src = 4'h0; tick();
    rd(1, v); chk("t3_ipend", v, 32'h8);
    chk("t3_masked", 32'(Interrupt), 32'h0);
    wr(0, 32'h8);
    chk("t3_edgeA", 32'(Interrupt), 32'h0);
    tick();
    chk("t3_edgeB", 32'(Interrupt), 32'h1);
    check_all("t3");

    // Exception while REQ
    exc_src = 3'b001; #1;
    chk("t4_exc_comb", 32'(Exception), 32'h1);
    check_all("t4_pre");
    tick(); exc_src = 3'b000;
    rd(2, v); chk("t4_cause", v, 32'h80000000);
    rd(3, v); chk("t4_sticky", v, 32'h101);
    rd(1, v); chk("t4_pending", v, 32'h8);
    kernel = 1; tick(); kernel = 0; tick(); tick();
    chk("t4_reint", 32'(Interrupt), 32'h1);
    kernel = 1; tick(); wr(1, 32'h8); wr(3, 32'h701); kernel = 0; tick();
    check_all("t4_ret");

    // Set wins over same-cycle clear
    wr(0, 32'h0);
    irq_src = 4'h1; tick(); irq_src = 4'h0; tick();
    irq_src = 4'h1; wr(1, 32'h1); irq_src = 4'h0;
    rd(1, v); chk("t5_set_wins", v, 32'h1);
    check_all("t5");

    // Reset while in service
    wr(0, 32'h1); tick(); kernel = 1; tick();
    chk("t6_svc", 32'(in_service), 32'h1);
    reset = 0; #1; model_reset();
    kernel = 0; exc_src = 3'b100; #1;
    chk("t6_exc_in_reset", 32'(Exception), 32'h1);
    check_all("t6_reset");
    exc_src = 3'b000; reset = 1;
    tick();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      irq_src = 4'($urandom_range(0, 15));
      exc_src = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      if ($urandom_range(0, 3) == 0) kernel = ~kernel;
      if ($urandom_range(0, 3) == 0) begin
        MemWr = 1; Addr = BASE + 32'($urandom_range(0, 19)); WriteData = $urandom;
      end
      tick();
      MemWr = 0; Addr = 32'h0; WriteData = 32'h0;
      check_all("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Interrupt/exception controller between the peripherals and the single-cycle core.
- Edge-detects and latches peripheral interrupt sources (timer, UART send/receive, spare), applies a mask, priority-selects one source and raises the core's Interrupt request.
- Forwards core exception conditions, records cause, and tracks kernel entry/exit via PC[31].
- Software sees a memory-mapped register block on the peripheral bus; its read data is OR-combined with the other read sources.

Parameters:
NSRC, 4, number of interrupt sources (1..8); index 0 is highest priority
BASE_ADDR, 32'h40000030, byte address of IMASK; register block occupies BASE_ADDR..BASE_ADDR+12

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  asynchronous, active-low; clears all state
irq_src  in  NSRC  level interrupt sources; a rising edge creates a pending request
exc_src  in  3  {core_hazard, PC_overflow, ALU_overflow} from the core, same-cycle
kernel  in  1  PC[31] of the core; 1 = handler/kernel mode
MemRd  in  1  bus read strobe
MemWr  in  1  bus write strobe
Addr  in  32  bus byte address
WriteData  in  32  bus write data
ReadData  out  32  read data; 0 when not selected
Interrupt  out  1  interrupt request to the PC logic
Exception  out  1  exception request to the PC logic
in_service  out  1  1 while the FSM is in SVC

Behaviour:
- Interface: one clock, clk. Asynchronous active-low reset, reset.
- Registers (word addresses, Addr[1:0] ignored):
  - BASE+0 IMASK, RW, bits [NSRC-1:0]; 1 = enabled; reset 0.
  - BASE+4 IPEND, R. Write-1-to-clear; reset 0.
  - BASE+8 ICAUSE, R. Bit31 = last entry was an exception; [2:0] = source id or exception code (0 ALU_ovf, 1 PC_ovf, 2 hazard); reset 0.
  - BASE+12 ICTRL, RW. Bit0 GIE, reset 0. Bits [10:8] = sticky exception flags, write-1-to-clear.
- ReadData is combinational: MemRd && address hit gives the register value, otherwise 32'h0. Unmapped offsets read 0 and writes to them are ignored.
- Edge detect: src_q <= irq_src each edge. A new event is irq_src & ~src_q.
- IPEND update, next = (IPEND & ~w1c) | new_event. Set wins over a same-cycle clear.
- Exception is combinational: |exc_src && !kernel. There is no latency, because the faulting instruction must trap in the same cycle.
- Each asserted exc_src bit sets its ICTRL sticky flag at the edge, regardless of kernel.
- FSM states:
  - IDLE. If Exception is high at the edge: ICAUSE <= {1, code of highest set bit in the order ALU_ovf > PC_ovf > hazard}, go to SVC. Otherwise, if GIE && |(IPEND & IMASK) && !kernel: ICAUSE <= {0, lowest set index}, go to REQ.
  - REQ. Interrupt = !kernel (combinational). Go to SVC when kernel is sampled 1. An exception arriving while in REQ overwrites ICAUSE as exception and goes to SVC.
  - SVC. Interrupt = 0 and in_service = 1. Go to IDLE when kernel is sampled 0 (handler returned).
- Latency, source rising before edge E1:
  - IPEND set at E1.
  - REQ at E2; Interrupt high after E2.
  - Core vectors at E3.
  - SVC at E4; Interrupt already low after E3 because it is gated by kernel.
- Source still pending after return: IDLE for exactly one cycle, then REQ again. No back-to-back vectoring without a user-mode cycle.
- Masked or GIE=0 pending bits stay in IPEND. They fire once enabled.
- A source held high does not re-pend. A new rising edge is required.
- Reset mid-operation: all state to IDLE, registers 0, Interrupt = 0. Exception still follows exc_src combinationally.

Decomposition:
- Shared package irq_pkg:
  - FSM state encoding (IDLE=2'd0, REQ=2'd1, SVC=2'd2).
  - Register offsets (0, 4, 8, 12).
  - Exception codes.
  - Default vector constants 32'h80000004 / 32'h80000008 for use by the PC logic.
- One sub-module: irq_prio_enc. Parameterised lowest-index-first priority encoder with a valid output, used for both IPEND&IMASK and exc_src.

Test Plan:
- GIE=1, IMASK=4'b0001, pulse irq_src[0] while kernel=0 -> IPEND=1 after E1; Interrupt high after E2; drive kernel=1 at E3 -> Interrupt low, in_service=1, ICAUSE=32'h0.
- irq_src=4'b0110 simultaneous edge, IMASK=4'hF -> ICAUSE[2:0]=1. After return with W1C of bit1, controller re-enters REQ one cycle later; ICAUSE[2:0]=2.
- IMASK=0, edge on irq_src[3] -> IPEND=4'b1000, Interrupt stays 0. Write IMASK=4'h8 -> Interrupt high two edges later.
- In REQ, pulse exc_src=3'b001 with kernel=0 -> Exception=1 same cycle; ICAUSE=32'h80000000; sticky ICTRL[8]=1; Interrupt source stays pending.
- W1C of IPEND bit0 on the same edge as a new irq_src[0] edge -> IPEND[0] remains 1.
- Assert reset low while in SVC -> state IDLE, IPEND/IMASK/ICAUSE/ICTRL=0, Interrupt=0, ReadData=0.
